// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, IF/ID output register plus 1-entry skid; response->if_valid_o in 1 cycle.
// Backpressure: stall_i holds the output; requests issue only when skid is empty and the output will be free.
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_write_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;

    logic consume, out_free, req_vld, hs, take;

    assign consume  = out_vld_q && !stall_i;
    assign out_free = !out_vld_q || consume;
    assign req_vld  = rst_n && (state_q == S_REQ) && !skid_vld_q && out_free && !flush_i;
    assign hs       = req_vld && imem_req_ready_i;
    // Responses only count while a live request is pending; S_REQ/S_DROP responses never load.
    assign take     = (state_q == S_WAIT) && imem_rsp_valid_i;

    assign imem_req_valid_o = req_vld;
    assign imem_addr_o      = pc_i;
    assign pc_write_o       = hs;
    assign if_valid_o       = out_vld_q;
    assign if_pc_o          = out_pc_q;
    assign if_instr_o       = out_instr_q;

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        out_vld_d    = out_vld_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        skid_vld_d   = skid_vld_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        case (state_q)
            S_REQ: begin
                if (hs) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_i;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i)
                    state_d = S_REQ;
                else if (flush_i)
                    state_d = S_DROP;
            end
            S_DROP: begin
                if (imem_rsp_valid_i)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (flush_i) begin
            out_vld_d   = 1'b0;
            out_instr_d = NOP_INSTR;
            skid_vld_d  = 1'b0;
        end else if (consume) begin
            if (skid_vld_q) begin
                out_pc_d    = skid_pc_q;
                out_instr_d = skid_instr_q;
                skid_vld_d  = 1'b0;
            end else if (take) begin
                out_pc_d    = req_pc_q;
                out_instr_d = imem_rsp_data_i;
            end else begin
                out_vld_d   = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end else if (!out_vld_q) begin
            if (take) begin
                out_vld_d   = 1'b1;
                out_pc_d    = req_pc_q;
                out_instr_d = imem_rsp_data_i;
            end
        end else if (take) begin
            skid_vld_d   = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rsp_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            req_pc_q     <= '0;
            out_vld_q    <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= NOP_INSTR;
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            out_vld_q    <= out_vld_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            skid_vld_q   <= skid_vld_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue-based fetch model plus a bench-side memory with variable latency.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pc_write_o;
    logic        stall_i;
    logic        flush_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    instr_fetch #(.DATA_WIDTH(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_i             (pc_i),
        .pc_write_o       (pc_write_o),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: held instructions in order (front = IF/ID output).
    ent_t        q[$];
    bit          m_inflight = 0;
    bit          m_drop     = 0;
    logic [31:0] m_ipc      = '0;
    logic [31:0] m_pc_idle  = '0;

    // Bench-side memory.
    bit          mem_pend  = 0;
    int          mem_cnt   = 0;
    bit          mem_stale = 0;
    bit          mem_fire  = 0;
    logic [31:0] pc_reg    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        int  phase;
        bit  consume, exp_req, hs;
        rst_n            = 1'b0;
        pc_i             = '0;
        stall_i          = 1'b0;
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;

        for (int c = 0; c < 3000; c++) begin
            cyc   = c;
            phase = c / 1000;
            @(negedge clk);
            if (c < 2)
                rst_n = 1'b0;
            else if (phase == 2)
                rst_n = ($urandom_range(0, 49) != 0);
            else
                rst_n = ($urandom_range(0, 199) != 0);
            stall_i          = (phase >= 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            flush_i          = (phase == 2) ? ($urandom_range(0, 6) == 0) : 1'b0;
            imem_req_ready_i = (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pc_i             = pc_reg;

            mem_fire = 0;
            imem_rsp_data_i = $urandom;
            if (mem_stale) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = 32'h1234_5678;
                mem_fire         = 1;
            end else if (mem_pend && mem_cnt == 0) begin
                imem_rsp_valid_i = 1'b1;
                mem_fire         = 1;
            end else if (!mem_pend && !m_inflight && $urandom_range(0, 24) == 0) begin
                imem_rsp_valid_i = 1'b1;   // unsolicited response, must be ignored
            end else begin
                imem_rsp_valid_i = 1'b0;
            end

            #1;
            consume = (q.size() > 0) && !stall_i;
            exp_req = rst_n && !m_inflight && (q.size() - int'(consume) == 0) && !flush_i;
            hs      = exp_req && imem_req_ready_i;
            check("req_valid", {31'd0, imem_req_valid_o}, {31'd0, exp_req});
            check("pc_write",  {31'd0, pc_write_o},       {31'd0, hs});
            check("imem_addr", imem_addr_o, pc_i);
            check("if_valid",  {31'd0, if_valid_o}, {31'd0, q.size() > 0});
            check("if_pc",     if_pc_o,    (q.size() > 0) ? q[0].pc : m_pc_idle);
            check("if_instr",  if_instr_o, (q.size() > 0) ? q[0].instr : NOP);

            @(posedge clk);
            if (mem_fire) begin
                mem_pend  = 0;
                mem_stale = 0;
            end else if (mem_pend && mem_cnt > 0) begin
                mem_cnt--;
            end

            if (!rst_n) begin
                q.delete();
                m_inflight = 0;
                m_drop     = 0;
                m_pc_idle  = '0;
                mem_stale  = mem_pend;
                mem_pend   = 0;
            end else begin
                if (flush_i) begin
                    q.delete();
                    if (m_inflight && !imem_rsp_valid_i) begin
                        m_drop = 1;
                    end else begin
                        m_inflight = 0;
                        m_drop     = 0;
                    end
                end else begin
                    if (consume) void'(q.pop_front());
                    if (m_inflight && imem_rsp_valid_i) begin
                        if (!m_drop) q.push_back('{pc: m_ipc, instr: imem_rsp_data_i});
                        m_inflight = 0;
                        m_drop     = 0;
                    end
                    if (hs) begin
                        m_inflight = 1;
                        m_ipc      = pc_i;
                        mem_pend   = 1;
                        mem_cnt    = (phase == 0) ? 0 : $urandom_range(0, 3);
                    end
                end
                if (q.size() > 0) m_pc_idle = q[0].pc;
            end

            if (hs) pc_reg = pc_reg + 32'd4;
            if ($urandom_range(0, 19) == 0) pc_reg = {$urandom_range(0, 32'h3FFF), 2'b00};
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, setting the width of address, PC and instruction.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction value shown while no instruction is held.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The module SHALL have port pc_i, input, DATA_WIDTH bits: the current fetch address from the program counter.
REQ-006 The module SHALL have port pc_write_o, output, 1 bit: advances the program counter by one step.
REQ-007 The module SHALL have port stall_i, input, 1 bit: decode cannot accept the IF/ID output this cycle.
REQ-008 The module SHALL have port flush_i, input, 1 bit: discard all fetched and in-flight instructions.
REQ-009 The module SHALL have port imem_req_valid_o, output, 1 bit: instruction memory request valid.
REQ-010 The module SHALL have port imem_req_ready_i, input, 1 bit: memory accepts the request.
REQ-011 The module SHALL have port imem_addr_o, output, DATA_WIDTH bits: the request address.
REQ-012 The module SHALL have port imem_rsp_valid_i, input, 1 bit: response data is valid; there is no back-pressure on responses.
REQ-013 The module SHALL have port imem_rsp_data_i, input, DATA_WIDTH bits: the fetched instruction.
REQ-014 The module SHALL have port if_valid_o, output, 1 bit: the IF/ID register holds a valid instruction.
REQ-015 The module SHALL have port if_pc_o, output, DATA_WIDTH bits: the PC of the held instruction.
REQ-016 The module SHALL have port if_instr_o, output, DATA_WIDTH bits: the held instruction.

Function
REQ-017 The FSM SHALL have states S_REQ, S_WAIT and S_DROP, with at most one memory request outstanding.
REQ-018 The "consume" event SHALL be defined as if_valid_o && !stall_i; the "output free" condition as !if_valid_o || consume.
REQ-019 imem_req_valid_o SHALL be asserted only in S_REQ when the skid entry is empty, the output is free, and flush_i = 0.
REQ-020 imem_req_valid_o SHALL be combinational, and imem_addr_o SHALL equal pc_i.
REQ-021 On the handshake (imem_req_valid_o && imem_req_ready_i), the block SHALL latch pc_i into req_pc and go to S_WAIT.
REQ-022 pc_write_o SHALL equal the handshake, so it is high for exactly one cycle per accepted request and never during flush.
REQ-023 In S_WAIT with imem_rsp_valid_i, if the output is free, {req_pc, rsp_data} SHALL load into the IF/ID register with if_valid_o = 1.
REQ-024 In the same S_WAIT response case, if the output is not free, the response SHALL load into the 1-entry skid buffer.
REQ-025 After an S_WAIT response is taken (output or skid), the FSM SHALL go to S_REQ.
REQ-026 The response-to-if_valid_o latency SHALL be 1 cycle; the request-handshake-to-next-request minimum SHALL be 2 cycles with a 0-wait memory.
REQ-027 On consume with the skid entry valid, the skid contents SHALL move to the output register and the skid SHALL clear.
REQ-028 On consume with the skid entry empty and no response arriving, if_valid_o SHALL clear to 0 and if_instr_o SHALL be set to NOP_INSTR.
REQ-029 flush_i SHALL have priority over all other events and SHALL clear if_valid_o and the skid valid bit on the next edge.
REQ-030 On flush_i, if_instr_o SHALL be set to NOP_INSTR on the next edge.
REQ-031 On flush_i in S_WAIT with no response that cycle, the FSM SHALL go to S_DROP.
REQ-032 On flush_i in S_WAIT with a response that same cycle, the response SHALL be discarded and the FSM SHALL go to S_REQ.
REQ-033 In S_DROP, the next response SHALL be discarded and the FSM SHALL go to S_REQ; requests SHALL stay low while in S_DROP.
REQ-034 A response arriving in S_REQ or S_DROP-discard SHALL never reach the outputs; responses in S_REQ are protocol violations and SHALL be ignored.
REQ-035 While stall_i = 1 with if_valid_o = 1, the outputs SHALL hold stable.

Reset
REQ-036 When rst_n = 0 at a clock edge, the FSM SHALL go to S_REQ.
REQ-037 When rst_n = 0 at a clock edge, if_valid_o SHALL be set to 0, if_pc_o to 0, and if_instr_o to NOP_INSTR.
REQ-038 When rst_n = 0 at a clock edge, the skid valid bit SHALL clear and req_pc SHALL be set to 0.
REQ-039 rst_n = 0 SHALL force imem_req_valid_o = 0 and pc_write_o = 0 combinationally.
REQ-040 After reset, a response to a pre-reset in-flight request SHALL be ignored, because the FSM is in S_REQ.
REQ-041 Reset mid-S_WAIT SHALL behave as REQ-036 to REQ-040.

Verification
REQ-042 Reset then 0-wait memory, pc_i=0x0/0x4, rsp 0x00500093 -> pc_write_o pulses 1 cycle; next cycle if_valid_o=1, if_pc_o=0x0, if_instr_o=0x00500093.
REQ-043 With ready low for 3 cycles, pc_i=0x100 -> imem_req_valid_o held with addr 0x100, pc_write_o=0 until ready, then one pulse.
REQ-044 Output valid with stall_i=1, response 0x00A00113 arrives -> skid filled, no new request; stall_i drops -> output becomes 0x00A00113 next cycle.
REQ-045 flush_i in S_WAIT, response 0xDEADBEEF two cycles later -> if_valid_o=0 with NOP 0x00000013, response dropped, next request issued at current pc_i.
REQ-046 flush_i the same cycle as a response -> response discarded, FSM in S_REQ, pc_write_o=0 that cycle.
REQ-047 rst_n low for 1 cycle while in S_WAIT with valid output -> all outputs at reset values; a late response 0x12345678 never appears.
